// File: rtl/ant_pkg.sv
// rtl/ant_pkg.sv - shared encodings for the ant turn scheduler
// Purpose: move encodings, scheduler state enum and the pheromone field width default.
// Ports: none (package).
package ant_pkg;

  typedef enum logic [1:0] {
    HALT    = 2'd0,
    RIGHT   = 2'd1,
    LEFT    = 2'd2,
    FORWARD = 2'd3
  } move_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int PH_WIDTH_DEF = 2;

endpackage

// File: rtl/ant_turn_sched_if.sv
// rtl/ant_turn_sched_if.sv - maze-side move/sensor bundle
// Purpose: groups the move handshake and the sensor response between scheduler and maze.
// Signals: mv_valid/mv_ready/mv_move/mv_id (move), sns_valid/sns_l/sns_r/sns_hit/sns_escape (sensors).
// Optional macro PH_ARB_EN adds mv_ph_drop and sns_ph.
// Modports: master = scheduler side, slave = maze side.
interface ant_turn_sched_if #(
  parameter int ID_W = 2
`ifdef PH_ARB_EN
  , parameter int PH_W = ant_pkg::PH_WIDTH_DEF
`endif
);

  logic            mv_valid;
  logic            mv_ready;
  logic [1:0]      mv_move;
  logic [ID_W-1:0] mv_id;
  logic            sns_valid;
  logic            sns_l;
  logic            sns_r;
  logic            sns_hit;
  logic            sns_escape;
`ifdef PH_ARB_EN
  logic [PH_W-1:0] mv_ph_drop;
  logic [PH_W-1:0] sns_ph;

  modport master (
    output mv_valid, mv_move, mv_id, mv_ph_drop,
    input  mv_ready, sns_valid, sns_l, sns_r, sns_hit, sns_escape, sns_ph
  );
  modport slave (
    input  mv_valid, mv_move, mv_id, mv_ph_drop,
    output mv_ready, sns_valid, sns_l, sns_r, sns_hit, sns_escape, sns_ph
  );
`else
  modport master (
    output mv_valid, mv_move, mv_id,
    input  mv_ready, sns_valid, sns_l, sns_r, sns_hit, sns_escape
  );
  modport slave (
    input  mv_valid, mv_move, mv_id,
    output mv_ready, sns_valid, sns_l, sns_r, sns_hit, sns_escape
  );
`endif

endinterface

// File: rtl/ant_turn_sched_rr_pick.sv
// rtl/ant_turn_sched_rr_pick.sv - combinational round-robin finder (module rr_pick)
// Purpose: returns the first set bit of active_i searching from last_i+1 with wrap-around.
// Ports: active_i (candidate mask), last_i (previous winner), next_o (winner), none_o (mask empty).
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    active_i,
  input  logic [ID_W-1:0] last_i,
  output logic [ID_W-1:0] next_o,
  output logic            none_o
);

  logic [ID_W-1:0] idx;

  always_comb begin
    next_o = '0;
    none_o = 1'b1;
    idx    = '0;
    // Walk farthest-first so the nearest active index after last_i is written last and wins.
    for (int off = N; off >= 1; off--) begin
      idx = ID_W'((int'(last_i) + off) % N);
      if (active_i[idx]) begin
        next_o = idx;
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ant_turn_sched.sv
// rtl/ant_turn_sched.sv - round-robin turn scheduler sharing one maze move port among ants
// Purpose: issues one move per active ant in turn, routes the sensor reply back to that ant,
//   retires escaped ants, counts steps per ant, and flags response timeouts.
// Ports: clk, rst (async active-high); ant_move (2 bits per ant); maze (master side of
//   ant_turn_sched_if); ant_l/ant_r/ant_hit/ant_escape (registered per-ant sensors);
//   ant_step (per-ant update pulse); escaped (sticky retired mask); step_cnt (CNT_W per ant,
//   saturating); done (all escaped); err_timeout (sticky).
// Optional macro PH_ARB_EN adds PH_WIDTH, ant_ph_drop, ant_ph_detected and the pheromone path.
module ant_turn_sched
  import ant_pkg::*;
#(
  parameter int N_ANTS  = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
`ifdef PH_ARB_EN
  , parameter int PH_WIDTH = PH_WIDTH_DEF
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*N_ANTS-1:0]       ant_move,
  ant_turn_sched_if.master          maze,
  output logic [N_ANTS-1:0]         ant_l,
  output logic [N_ANTS-1:0]         ant_r,
  output logic [N_ANTS-1:0]         ant_hit,
  output logic [N_ANTS-1:0]         ant_escape,
  output logic [N_ANTS-1:0]         ant_step,
  output logic [N_ANTS-1:0]         escaped,
  output logic [CNT_W*N_ANTS-1:0]   step_cnt,
  output logic                      done,
  output logic                      err_timeout
`ifdef PH_ARB_EN
  , input  logic [PH_WIDTH*N_ANTS-1:0] ant_ph_drop
  , output logic [PH_WIDTH*N_ANTS-1:0] ant_ph_detected
`endif
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  sched_state_e                 state_q, state_d;
  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic [ID_W-1:0]              last_q, last_d;
  move_e                        mv_move_q, mv_move_d;
  logic                         mv_valid_q, mv_valid_d;
  logic [TMR_W-1:0]             tmr_q, tmr_d;
  logic [N_ANTS-1:0]            l_q, l_d, r_q, r_d, hit_q, hit_d, esc_q, esc_d;
  logic [N_ANTS-1:0]            step_q, step_d;
  logic [N_ANTS-1:0]            escaped_q, escaped_d;
  logic [N_ANTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic [N_ANTS-1:0][1:0]       move_arr;
  logic [ID_W-1:0]              pick_next;
  logic                         pick_none;
`ifdef PH_ARB_EN
  logic [PH_WIDTH-1:0]               ph_drop_q, ph_drop_d;
  logic [N_ANTS-1:0][PH_WIDTH-1:0]   ph_det_q, ph_det_d;
  logic [N_ANTS-1:0][PH_WIDTH-1:0]   ph_drop_arr;

  assign ph_drop_arr     = ant_ph_drop;
  assign maze.mv_ph_drop = ph_drop_q;
  assign ant_ph_detected = ph_det_q;
`endif

  assign move_arr = ant_move;

  rr_pick #(.N(N_ANTS), .ID_W(ID_W)) u_pick (
    .active_i (~escaped_q),
    .last_i   (last_q),
    .next_o   (pick_next),
    .none_o   (pick_none)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    mv_move_d  = mv_move_q;
    mv_valid_d = mv_valid_q;
    tmr_d      = tmr_q;
    l_d        = l_q;
    r_d        = r_q;
    hit_d      = hit_q;
    esc_d      = esc_q;
    step_d     = '0;
    escaped_d  = escaped_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
`ifdef PH_ARB_EN
    ph_drop_d  = ph_drop_q;
    ph_det_d   = ph_det_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_none) begin
          state_d = DONE;
        end else begin
          ptr_d      = pick_next;
          mv_move_d  = move_e'(move_arr[pick_next]);
          mv_valid_d = 1'b1;
`ifdef PH_ARB_EN
          ph_drop_d  = ph_drop_arr[pick_next];
`endif
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (maze.mv_ready) begin
          mv_valid_d = 1'b0;
          tmr_d      = '0;
          last_d     = ptr_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // A response in the last allowed cycle still counts: sensor check comes first.
        if (maze.sns_valid) begin
          l_d[ptr_q]    = maze.sns_l;
          r_d[ptr_q]    = maze.sns_r;
          hit_d[ptr_q]  = maze.sns_hit;
          esc_d[ptr_q]  = maze.sns_escape;
          step_d[ptr_q] = 1'b1;
          if (cnt_q[ptr_q] != '1) begin
            cnt_d[ptr_q] = cnt_q[ptr_q] + CNT_W'(1);
          end
          if (maze.sns_escape) begin
            escaped_d[ptr_q] = 1'b1;
          end
`ifdef PH_ARB_EN
          ph_det_d[ptr_q] = maze.sns_ph;
`endif
          state_d = IDLE;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      last_q     <= ID_W'(N_ANTS - 1);
      mv_move_q  <= HALT;
      mv_valid_q <= 1'b0;
      tmr_q      <= '0;
      l_q        <= '0;
      r_q        <= '0;
      hit_q      <= '0;
      esc_q      <= '0;
      step_q     <= '0;
      escaped_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
`ifdef PH_ARB_EN
      ph_drop_q  <= '0;
      ph_det_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      mv_move_q  <= mv_move_d;
      mv_valid_q <= mv_valid_d;
      tmr_q      <= tmr_d;
      l_q        <= l_d;
      r_q        <= r_d;
      hit_q      <= hit_d;
      esc_q      <= esc_d;
      step_q     <= step_d;
      escaped_q  <= escaped_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`ifdef PH_ARB_EN
      ph_drop_q  <= ph_drop_d;
      ph_det_q   <= ph_det_d;
`endif
    end
  end

  assign maze.mv_valid = mv_valid_q;
  assign maze.mv_move  = mv_move_q;
  assign maze.mv_id    = ptr_q;
  assign ant_l         = l_q;
  assign ant_r         = r_q;
  assign ant_hit       = hit_q;
  assign ant_escape    = esc_q;
  assign ant_step      = step_q;
  assign escaped       = escaped_q;
  assign step_cnt      = cnt_q;
  assign done          = (state_q == DONE);
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_ant_turn_sched.sv
// tb/tb_ant_turn_sched.sv - self-checking bench for ant_turn_sched
module tb_ant_turn_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ant_move;
  logic [3:0]  ant_l, ant_r, ant_hit, ant_escape, ant_step, escaped;
  logic [63:0] step_cnt;
  logic        done, err_timeout;
`ifdef PH_ARB_EN
  logic [7:0]  ant_ph_drop, ant_ph_detected;
`endif

  always #5 clk = ~clk;

  ant_turn_sched_if #(.ID_W(2)) ifc ();

  ant_turn_sched #(.N_ANTS(4), .ID_W(2), .CNT_W(16), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ant_move    (ant_move),
    .maze        (ifc.master),
    .ant_l       (ant_l),
    .ant_r       (ant_r),
    .ant_hit     (ant_hit),
    .ant_escape  (ant_escape),
    .ant_step    (ant_step),
    .escaped     (escaped),
    .step_cnt    (step_cnt),
    .done        (done),
    .err_timeout (err_timeout)
`ifdef PH_ARB_EN
    , .ant_ph_drop     (ant_ph_drop)
    , .ant_ph_detected (ant_ph_detected)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  id;
    logic [3:0]  sns;
    logic [15:0] cnt;
  } sb_t;

  typedef struct {
    logic [7:0] moves;
    logic [3:0] sns;
    logic [1:0] exp_id;
  } vec_t;

  sb_t        sbq[$];
  vec_t       vt[8];
  logic [1:0] m_last;
  logic [3:0] m_esc;
  int         m_cnt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last = 2'd3;
    m_esc  = 4'b0000;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    sbq.delete();
  endtask

  function automatic logic [1:0] m_next();
    logic [1:0] c;
    c = m_last;
    for (int k = 0; k < 4; k++) begin
      c = c + 2'd1;
      if (!m_esc[c]) return c;
    end
    return 2'd0;
  endfunction

  task automatic sb_check();
    sb_t e;
    e = sbq.pop_front();
    chk("ant_step",   {60'd0, ant_step}, {60'd0, 4'b0001 << e.id});
    chk("ant_l",      {63'd0, ant_l[e.id]},      {63'd0, e.sns[3]});
    chk("ant_r",      {63'd0, ant_r[e.id]},      {63'd0, e.sns[2]});
    chk("ant_hit",    {63'd0, ant_hit[e.id]},    {63'd0, e.sns[1]});
    chk("ant_escape", {63'd0, ant_escape[e.id]}, {63'd0, e.sns[0]});
    chk("step_cnt",   {48'd0, step_cnt[16*e.id +: 16]}, {48'd0, e.cnt});
    chk("escaped",    {60'd0, escaped}, {60'd0, m_esc});
  endtask

  // sns = {l, r, hit, escape}; sns_delay < 0 leaves the DUT in WAIT on return.
  task automatic turn(input logic [3:0] sns, input int rdy_wait, input int sns_delay,
                      output logic [1:0] id, output int t);
    logic [1:0] eid;
    logic [1:0] emove;
    int n;
    eid = m_next();
    n = 0;
    while (ifc.mv_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("mv_valid_seen", {63'd0, ifc.mv_valid}, 64'd1);
    id = ifc.mv_id;
    t  = cyc;
    chk("mv_id", {62'd0, id}, {62'd0, eid});
    emove = ant_move[2*eid +: 2];
    chk("mv_move", {62'd0, ifc.mv_move}, {62'd0, emove});
    for (int k = 0; k < rdy_wait; k++) begin
      ant_move = 8'($urandom);
      if (k == 3) begin
        ifc.sns_valid  = 1'b1;
        ifc.sns_escape = 1'b1;
      end
      tick();
      ifc.sns_valid  = 1'b0;
      ifc.sns_escape = 1'b0;
      chk("hold_valid",  {63'd0, ifc.mv_valid}, 64'd1);
      chk("hold_move",   {62'd0, ifc.mv_move}, {62'd0, emove});
      chk("hold_id",     {62'd0, ifc.mv_id}, {62'd0, eid});
      chk("hold_nostep", {60'd0, ant_step}, 64'd0);
    end
    ifc.mv_ready = 1'b1;
    tick();
    ifc.mv_ready = 1'b0;
    m_last = eid;
    chk("mv_valid_drop", {63'd0, ifc.mv_valid}, 64'd0);
    if (sns_delay >= 0) begin
      repeat (sns_delay) begin
        tick();
        chk("wait_nostep", {60'd0, ant_step}, 64'd0);
      end
      {ifc.sns_l, ifc.sns_r, ifc.sns_hit, ifc.sns_escape} = sns;
      ifc.sns_valid = 1'b1;
      m_cnt[eid]++;
      if (sns[0]) m_esc[eid] = 1'b1;
      sbq.push_back('{eid, sns, 16'(m_cnt[eid])});
      tick();
      ifc.sns_valid = 1'b0;
      {ifc.sns_l, ifc.sns_r, ifc.sns_hit, ifc.sns_escape} = 4'b0000;
      sb_check();
    end
  endtask

  initial begin
    logic [1:0] id;
    int t;
    int tp;

    vt[0] = '{8'hE4, 4'b1000, 2'd0};
    vt[1] = '{8'hE4, 4'b0100, 2'd1};
    vt[2] = '{8'h1B, 4'b0011, 2'd2};
    vt[3] = '{8'h1B, 4'b1100, 2'd3};
    vt[4] = '{8'h4E, 4'b0110, 2'd0};
    vt[5] = '{8'hFF, 4'b1010, 2'd1};
    vt[6] = '{8'h00, 4'b0000, 2'd3};
    vt[7] = '{8'h93, 4'b1110, 2'd0};

    rst = 1'b1;
    ant_move = 8'h00;
    ifc.mv_ready = 1'b0;
    ifc.sns_valid = 1'b0;
    {ifc.sns_l, ifc.sns_r, ifc.sns_hit, ifc.sns_escape} = 4'b0000;
`ifdef PH_ARB_EN
    ant_ph_drop = 8'hA5;
    ifc.sns_ph  = 2'b11;
`endif
    model_reset();
    tp = 0;
    repeat (3) @(posedge clk);
    #1;

    chk("rst_mv_valid", {63'd0, ifc.mv_valid}, 64'd0);
    chk("rst_mv_id",    {62'd0, ifc.mv_id}, 64'd0);
    chk("rst_done",     {63'd0, done}, 64'd0);
    chk("rst_escaped",  {60'd0, escaped}, 64'd0);
    chk("rst_step_cnt", step_cnt, 64'd0);
    chk("rst_err",      {63'd0, err_timeout}, 64'd0);
    chk("rst_sensors",  {48'd0, ant_l, ant_r, ant_hit, ant_escape}, 64'd0);
    rst = 1'b0;

    // Round-robin table: ant 2 escapes on its first turn and is skipped afterwards.
    for (int i = 0; i < 8; i++) begin
      ant_move = vt[i].moves;
      turn(vt[i].sns, 0, 0, id, t);
      chk("tbl_id", {62'd0, id}, {62'd0, vt[i].exp_id});
      if (i >= 1 && i <= 3) chk("turn_period", 64'(t - tp), 64'd3);
      tp = t;
      if (i == 3) begin
        chk("cnt_after4", step_cnt, {4{16'd1}});
        chk("esc_after4", {60'd0, escaped}, 64'h4);
      end
    end

    // mv_ready held low: move/id stay captured, stray sns_valid in ISSUE is ignored.
    ant_move = 8'hE4;
    turn(4'b1100, 10, 0, id, t);
    chk("hold_turn_id", {62'd0, id}, 64'd1);

    // Response on the last allowed WAIT cycle beats the timeout.
    turn(4'b0100, 0, 7, id, t);
    chk("deadline_err", {63'd0, err_timeout}, 64'd0);

    // No response: timeout after 8 WAIT cycles, no step pulse.
    turn(4'b0000, 0, -1, id, t);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("to_err_early", {63'd0, err_timeout}, 64'd0);
      chk("to_nostep",    {60'd0, ant_step}, 64'd0);
    end
    tick();
    chk("to_err",    {63'd0, err_timeout}, 64'd1);
    chk("to_nostep", {60'd0, ant_step}, 64'd0);
    chk("to_cnt0",   {48'd0, step_cnt[15:0]}, 64'(m_cnt[0]));
    turn(4'b1110, 0, 0, id, t);
    chk("after_to_id", {62'd0, id}, 64'd1);

    // Async reset in WAIT.
    turn(4'b0000, 0, -1, id, t);
    rst = 1'b1;
    #1;
    chk("wrst_sensors", {48'd0, ant_l, ant_r, ant_hit, ant_escape}, 64'd0);
    chk("wrst_cnt",     step_cnt, 64'd0);
    chk("wrst_escaped", {60'd0, escaped}, 64'd0);
    chk("wrst_err",     {63'd0, err_timeout}, 64'd0);
    chk("wrst_valid",   {63'd0, ifc.mv_valid}, 64'd0);
`ifdef PH_ARB_EN
    chk("wrst_ph", {56'd0, ant_ph_detected}, 64'd0);
`endif
    model_reset();
    tick();
    rst = 1'b0;
    turn(4'b0010, 0, 0, id, t);
    chk("post_rst_id", {62'd0, id}, 64'd0);

    // Every ant escapes in order; done follows the final IDLE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) turn(4'b0011, 0, 0, id, t);
    chk("done_early", {63'd0, done}, 64'd0);
    tick();
    chk("done",        {63'd0, done}, 64'd1);
    chk("all_escaped", {60'd0, escaped}, 64'hF);
    repeat (5) begin
      tick();
      chk("done_no_valid", {63'd0, ifc.mv_valid}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
